// File: rtl/seg7_scan_capture.sv
// Recovers per-digit BCD values from a multiplexed common-anode 7-segment bus.
// A digit is captured once its anode/cathode pattern has held steady for SETTLE cycles.
module seg7_scan_capture #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SETTLE     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DIGITS-1:0]     anode,
    input  logic [7:0]                cathode,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     dp,
    output logic [NUM_DIGITS-1:0]     blank,
    output logic [NUM_DIGITS-1:0]     err,
    output logic                      frame_valid
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned VAL_W = 4;
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] SETTLE_PRE = CNT_W'(SETTLE - 1);

    logic [NUM_DIGITS-1:0] anode_q;
    logic [7:0]            cathode_q;
    logic [CNT_W-1:0]      stable_cnt;
    logic [NUM_DIGITS-1:0] seen;

    logic                  changed_c;
    logic                  strobe_c;
    logic [NUM_DIGITS-1:0] sel_c;
    logic                  onehot_c;
    logic [NUM_DIGITS-1:0] hit_c;
    logic [NUM_DIGITS-1:0] seen_next_c;
    logic                  complete_c;
    logic [VAL_W-1:0]      dec_val_c;
    logic                  dec_blank_c;
    logic                  dec_err_c;

    // Input sampling and stability counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_q    <= '1;
            cathode_q  <= 8'hFF;
            stable_cnt <= '0;
        end else begin
            anode_q   <= anode;
            cathode_q <= cathode;
            if (changed_c) begin
                stable_cnt <= '0;
            end else if (stable_cnt != SETTLE_MAX) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

    // Strobe fires only on the SETTLE-1 -> SETTLE step, so once per stable window
    always_comb begin
        changed_c   = ({anode, cathode} != {anode_q, cathode_q});
        strobe_c    = !changed_c && (stable_cnt == SETTLE_PRE);
        sel_c       = ~anode_q;
        onehot_c    = (sel_c != '0) && ((sel_c & (sel_c - NUM_DIGITS'(1))) == '0);
        hit_c       = (strobe_c && onehot_c) ? sel_c : '0;
        seen_next_c = seen | hit_c;
        complete_c  = (hit_c != '0) && (&seen_next_c);
    end

    // Active-low segment pattern back to a digit value
    always_comb begin
        dec_val_c   = 4'hE;
        dec_blank_c = 1'b0;
        dec_err_c   = 1'b0;
        case (cathode_q[6:0])
            7'h40: dec_val_c = 4'h0;
            7'h79: dec_val_c = 4'h1;
            7'h24: dec_val_c = 4'h2;
            7'h30: dec_val_c = 4'h3;
            7'h19: dec_val_c = 4'h4;
            7'h12: dec_val_c = 4'h5;
            7'h02: dec_val_c = 4'h6;
            7'h78: dec_val_c = 4'h7;
            7'h00: dec_val_c = 4'h8;
            7'h10: dec_val_c = 4'h9;
            7'h7F: begin
                dec_val_c   = 4'hF;
                dec_blank_c = 1'b1;
            end
            default: begin
                dec_val_c = 4'hE;
                dec_err_c = 1'b1;
            end
        endcase
    end

    // Per-digit capture registers and frame tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            dp          <= '0;
            blank       <= '1;
            err         <= '0;
            seen        <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (hit_c != '0) begin
                if (complete_c) begin
                    seen        <= '0;
                    frame_valid <= 1'b1;
                end else begin
                    seen <= seen_next_c;
                end
            end
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                if (hit_c[k]) begin
                    digits[4*k +: 4] <= dec_val_c;
                    dp[k]            <= ~cathode_q[7];
                    blank[k]         <= dec_blank_c;
                    err[k]           <= dec_err_c;
                end
            end
        end
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Recovers BCD digits from a multiplexed common-anode 7-segment display bus, so it runs in the opposite direction to the BCD-to-7-segment decoder.
- Samples the anode select and cathode pattern and waits for the pattern to settle.
- Decodes each settled cathode pattern back to a 4-bit value and stores it per digit.
- Flags a complete frame once every digit has been refreshed. Used as a display self-check and as a loopback monitor for the display path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines), range 1..8.
- SETTLE, 4, consecutive stable cycles required before a capture, range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- anode  in  NUM_DIGITS  digit select, active-low; bit k low selects digit k.
- cathode  in  8  segments, active-low (0 = lit); bit0=a … bit6=g, bit7=dp.
- digits  out  4*NUM_DIGITS  decoded value per digit; digit k is at [4k+3:4k].
- dp  out  NUM_DIGITS  decimal point lit, per digit.
- blank  out  NUM_DIGITS  digit captured with all of a–g dark.
- err  out  NUM_DIGITS  digit captured with an unrecognised pattern.
- frame_valid  out  1  one-cycle pulse when every digit has been captured since the last pulse.

Behaviour:
- **Reset values (async):**
  - digits = 0, dp = 0, blank = all 1, err = 0, frame_valid = 0.
  - seen mask = 0, stability counter = 0.
  - Sample registers: anode = all 1, cathode = 8'hFF.
- **Sampling:** {anode, cathode} is registered every edge.
  - Registered value differs from the previous registered value: counter clears to 0.
  - Otherwise the counter increments, saturating at SETTLE.
- **Capture strobe:** fires on the edge where the counter goes SETTLE-1 → SETTLE with the value unchanged. It fires once per stable window.
  - Net effect: pins held for SETTLE+1 consecutive edges update the outputs on the (SETTLE+1)th edge.
  - No further capture occurs until the value changes and settles again.
- **Valid select:** the strobe acts only if exactly one anode bit is low.
  - Zero or multiple low anode bits: the strobe is ignored; no output or seen change.
- **Decode of cathode[6:0] (active-low), digit value written:**
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9.
  - 0x7F → value 0xF, blank[k]=1, err[k]=0.
  - Any other pattern → value 0xE, err[k]=1, blank[k]=0.
  - Decoded 0–9 → blank[k]=0, err[k]=0.
- **Per capture on digit k:**
  - digits slice k, dp[k] = ~cathode[7], blank[k] and err[k] update together.
  - seen[k] is set.
  - Other digits are held.
- **Re-capture before frame completion:** capturing the same digit again overwrites its slice; the seen mask is unchanged.
- **Frame completion:** when a capture makes the seen mask all ones:
  - frame_valid = 1 on that same edge, for exactly one cycle.
  - The seen mask clears to 0 on that edge.
- **Reset mid-operation:** returns everything to reset values; a partially seen frame is discarded.
- **Widths:** counter is 4 bits and compares against SETTLE. The NUM_DIGITS=1 case is legal; every capture then pulses frame_valid.

Test Plan:
(NUM_DIGITS=4, SETTLE=4 throughout.)
1. Assert rst asynchronously mid-cycle → all outputs take reset values immediately; digits=16'h0000, blank=4'b1111, frame_valid=0.
2. Stability threshold:
   - anode=4'b1110, cathode=8'hA4 held 5 edges → after edge 5: digits[3:0]=2, dp[0]=0, blank[0]=0, err[0]=0.
   - Same stimulus held only 4 edges, then anode=4'b1111 → no update.
3. Full scan, 8 cycles per digit:
   - digit0=8'hF9, digit1=8'hB0, digit2=8'h99, digit3=8'h12.
   - → digits=16'h5431, dp=4'b1000, blank=0, err=0.
   - → frame_valid pulses once, on the digit3 capture edge.
   - Repeating the scan → second single pulse.
4. Invalid patterns:
   - digit1 cathode=8'hFF → digits[7:4]=F, blank[1]=1.
   - digit2 cathode=8'hAA → digits[11:8]=E, err[2]=1.
   - anode=4'b1100 held 20 cycles → no output change, no frame_valid.
5. Glitching: cathode alternates 8'hC0/8'hF9 every 2 cycles with anode=4'b1110 for 40 cycles → no capture; digits[3:0] keeps its prior value.
6. Reset mid-frame: capture digits 0–2, pulse rst, then capture digit 3 only → frame_valid stays 0. A following full scan produces exactly one pulse.
